// File: rtl/noc_route_demux.sv
// Wormhole packet demultiplexer: steers each packet from one input channel to one
// of NOUT buffered output ports chosen by the header's destination field.
module noc_route_demux #(
  parameter int W     = 9,
  parameter int NOUT  = 2,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(NOUT)
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [W-1:0]      In_data,
  input  logic              In_valid,
  output logic              In_ready,
  output logic [NOUT*W-1:0] Out_data,
  output logic [NOUT-1:0]   Out_valid,
  input  logic [NOUT-1:0]   Out_ready,
  output logic [AW-1:0]     S_data,
  output logic              S_valid,
  input  logic              S_ready,
  output logic [7:0]        drop_cnt
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [1:0] HEAD = 2'd0;
  localparam logic [1:0] BODY = 2'd1;
  localparam logic [1:0] DROP = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] lock;
  logic [AW-1:0] dest;
  logic [AW-1:0] target;
  logic          dest_ok;
  logic          tail;
  logic          tgt_full;
  logic          s_free;
  logic          accept;
  logic          route_hdr;

  logic [W-1:0]  mem    [NOUT][DEPTH];
  logic [PW-1:0] rd_ptr [NOUT];
  logic [PW-1:0] wr_ptr [NOUT];
  logic [CW-1:0] count  [NOUT];
  logic [NOUT-1:0] push;
  logic [NOUT-1:0] pop;

  logic          s_valid_q;
  logic [AW-1:0] s_data_q;
  logic [7:0]    drop_q;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign dest      = In_data[AW-1:0];
  assign tail      = In_data[W-1];
  assign dest_ok   = int'(dest) < NOUT;
  assign target    = (state == BODY) ? lock : dest;
  assign s_free    = !s_valid_q || S_ready;
  assign accept    = In_valid && In_ready;
  assign route_hdr = accept && (state == HEAD) && dest_ok;

  // A full target blocks the input even if it is being popped this cycle.
  always_comb begin
    tgt_full = 1'b0;
    for (int p = 0; p < NOUT; p++) begin
      if (target == AW'(p)) tgt_full = (count[p] == CW'(DEPTH));
    end
  end

  always_comb begin
    case (state)
      HEAD:    In_ready = dest_ok ? (!tgt_full && s_free) : 1'b1;
      BODY:    In_ready = !tgt_full;
      DROP:    In_ready = 1'b1;
      default: In_ready = 1'b0;
    endcase
  end

  always_comb begin
    push      = '0;
    pop       = '0;
    Out_valid = '0;
    Out_data  = '0;
    for (int p = 0; p < NOUT; p++) begin
      push[p]      = accept && ((state == BODY) || route_hdr) && (target == AW'(p));
      Out_valid[p] = (count[p] != '0);
      pop[p]       = Out_ready[p] && Out_valid[p];
      if (Out_valid[p]) Out_data[p*W +: W] = mem[p][rd_ptr[p]];
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state  <= HEAD;
      lock   <= '0;
      drop_q <= '0;
    end else if (accept) begin
      case (state)
        HEAD: begin
          if (dest_ok) begin
            if (!tail) begin
              state <= BODY;
              lock  <= dest;
            end
          end else begin
            if (drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (!tail) state <= DROP;
          end
        end
        BODY, DROP: if (tail) state <= HEAD;
        default:    state <= HEAD;
      endcase
    end
  end

  // A new route record wins over a same-cycle consume of the old one.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s_valid_q <= 1'b0;
      s_data_q  <= '0;
    end else if (route_hdr) begin
      s_valid_q <= 1'b1;
      s_data_q  <= dest;
    end else if (S_ready) begin
      s_valid_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int p = 0; p < NOUT; p++) begin
        rd_ptr[p] <= '0;
        wr_ptr[p] <= '0;
        count[p]  <= '0;
      end
    end else begin
      for (int p = 0; p < NOUT; p++) begin
        if (push[p]) wr_ptr[p] <= ptr_next(wr_ptr[p]);
        if (pop[p])  rd_ptr[p] <= ptr_next(rd_ptr[p]);
        case ({push[p], pop[p]})
          2'b10:   count[p] <= count[p] + CW'(1);
          2'b01:   count[p] <= count[p] - CW'(1);
          default: count[p] <= count[p];
        endcase
      end
    end
  end

  always_ff @(posedge CLK) begin
    for (int p = 0; p < NOUT; p++) begin
      if (push[p]) mem[p][wr_ptr[p]] <= In_data;
    end
  end

  assign S_valid  = s_valid_q;
  assign S_data   = s_data_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_noc_route_demux.sv
// Bench for noc_route_demux: a two-port and a three-port instance driven in turn,
// checked against a queue-based packet routing model.
module tb_noc_route_demux;

  typedef logic [31:0] word_t;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [8:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [2:0] out_ready = '0;
  logic       s_ready = 1'b0;
  logic       sel = 1'b0;

  logic        rdy2, rdy3;
  logic [17:0] od2;
  logic [26:0] od3;
  logic [1:0]  ov2;
  logic [2:0]  ov3;
  logic        sd2;
  logic [1:0]  sd3;
  logic        sv2, sv3;
  logic [7:0]  dc2, dc3;

  always #5 CLK = ~CLK;

  noc_route_demux #(.W(9), .NOUT(2), .DEPTH(4)) dut2 (
    .CLK(CLK), .RESET(RESET),
    .In_data(in_data), .In_valid(in_valid & ~sel), .In_ready(rdy2),
    .Out_data(od2), .Out_valid(ov2), .Out_ready(out_ready[1:0] & {2{~sel}}),
    .S_data(sd2), .S_valid(sv2), .S_ready(s_ready), .drop_cnt(dc2)
  );

  noc_route_demux #(.W(9), .NOUT(3), .DEPTH(4)) dut3 (
    .CLK(CLK), .RESET(RESET),
    .In_data(in_data), .In_valid(in_valid & sel), .In_ready(rdy3),
    .Out_data(od3), .Out_valid(ov3), .Out_ready(out_ready & {3{sel}}),
    .S_data(sd3), .S_valid(sv3), .S_ready(s_ready), .drop_cnt(dc3)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state
  int         nout = 2;
  int         m_state = 0;
  int         m_lock = 0;
  bit         m_s_valid = 1'b0;
  int         m_s_data = 0;
  int         m_drop = 0;
  bit         last_acc = 1'b1;
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];

  task automatic checkOutput(input string tag, input word_t actual, input word_t expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [8:0] d, input logic v, input logic [2:0] o, input logic s);
    in_data   = d;
    in_valid  = v;
    out_ready = o;
    s_ready   = s;
  endtask

  function automatic word_t cur_rdy();  return sel ? 32'(rdy3) : 32'(rdy2); endfunction
  function automatic word_t cur_ov();   return sel ? 32'(ov3)  : 32'(ov2);  endfunction
  function automatic word_t cur_sd();   return sel ? 32'(sd3)  : 32'(sd2);  endfunction
  function automatic word_t cur_sv();   return sel ? 32'(sv3)  : 32'(sv2);  endfunction
  function automatic word_t cur_drop(); return sel ? 32'(dc3)  : 32'(dc2);  endfunction
  function automatic word_t cur_od_all(); return sel ? 32'(od3) : 32'(od2); endfunction

  function automatic word_t cur_od(input int p);
    if (sel) return 32'(od3[p*9 +: 9]);
    if (p < 2) return 32'(od2[p*9 +: 9]);
    return '0;
  endfunction

  function automatic int qsize(input int p);
    case (p)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic qpush(input int p, input logic [8:0] v);
    case (p)
      0:       q0.push_back(v);
      1:       q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic qpop(input int p, output logic [8:0] v);
    case (p)
      0:       v = q0.pop_front();
      1:       v = q1.pop_front();
      default: v = q2.pop_front();
    endcase
  endtask

  function automatic int dest_of(input logic [8:0] d);
    return (nout == 2) ? int'(d[0]) : int'(d[1:0]);
  endfunction

  function automatic word_t exp_ov();
    word_t v = '0;
    for (int p = 0; p < nout; p++) v[p] = (qsize(p) != 0);
    return v;
  endfunction

  function automatic bit model_ready();
    int d = dest_of(in_data);
    case (m_state)
      0:       return (d < nout) ? ((qsize(d) < 4) && (!m_s_valid || s_ready)) : 1'b1;
      1:       return qsize(m_lock) < 4;
      default: return 1'b1;
    endcase
  endfunction

  task automatic model_reset();
    q0.delete(); q1.delete(); q2.delete();
    m_state = 0; m_lock = 0; m_s_valid = 1'b0; m_s_data = 0; m_drop = 0;
    last_acc = 1'b1;
  endtask

  task automatic model_accept();
    int d = dest_of(in_data);
    case (m_state)
      0: begin
        if (d < nout) begin
          qpush(d, in_data);
          m_s_valid = 1'b1;
          m_s_data  = d;
          if (!in_data[8]) begin m_state = 1; m_lock = d; end
        end else begin
          if (m_drop < 255) m_drop++;
          if (!in_data[8]) m_state = 2;
        end
      end
      1: begin
        qpush(m_lock, in_data);
        if (in_data[8]) m_state = 0;
      end
      default: if (in_data[8]) m_state = 0;
    endcase
  endtask

  // One clock: compare at the falling edge, advance the model, return just after the rising edge.
  task automatic cycle();
    bit rdy;
    logic [8:0] v;
    @(negedge CLK);
    rdy = model_ready();
    if (in_valid) checkOutput("in_ready", cur_rdy(), 32'(rdy));
    checkOutput("out_valid", cur_ov(), exp_ov());
    checkOutput("s_valid", cur_sv(), 32'(m_s_valid));
    checkOutput("s_data", cur_sd(), m_s_data);
    checkOutput("drop_cnt", cur_drop(), m_drop);
    for (int p = 0; p < nout; p++) begin
      if (out_ready[p] && qsize(p) != 0) begin
        qpop(p, v);
        checkOutput($sformatf("out_data%0d", p), cur_od(p), 32'(v));
      end
    end
    if (m_s_valid && s_ready) m_s_valid = 1'b0;
    last_acc = in_valid && rdy;
    if (last_acc) model_accept();
    @(posedge CLK);
    #1;
  endtask

  task automatic sendFlit(input logic [8:0] d, input logic [2:0] o, input logic s);
    int tries = 0;
    applyStimulus(d, 1'b1, o, s);
    do begin
      cycle();
      tries++;
    end while (!last_acc && tries < 16);
    if (!last_acc) checkOutput("send_timeout", 32'(last_acc), 32'd1);
    applyStimulus(d, 1'b0, o, s);
  endtask

  task automatic doReset();
    in_valid = 1'b0;
    RESET = 1'b1;
    #1;
    model_reset();
    checkOutput("rst_out_valid", cur_ov(), 32'd0);
    checkOutput("rst_s_valid", cur_sv(), 32'd0);
    checkOutput("rst_s_data", cur_sd(), 32'd0);
    checkOutput("rst_drop", cur_drop(), 32'd0);
    checkOutput("rst_out_data", cur_od_all(), 32'd0);
    @(posedge CLK);
    #1;
    RESET = 1'b0;
  endtask

  task automatic drain();
    applyStimulus(9'h000, 1'b0, 3'b111, 1'b1);
    repeat (8) cycle();
  endtask

  task automatic randomTraffic(input int n);
    logic [8:0] d = 9'($urandom_range(0, 511));
    for (int i = 0; i < n; i++) begin
      if (last_acc) d = 9'($urandom_range(0, 511));
      applyStimulus(d, ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      cycle();
    end
  endtask

  initial begin
    #2;
    doReset();

    $display("[TB] single-flit packet to port 1");
    sendFlit(9'h101, 3'b000, 1'b0);
    checkOutput("t1_out_valid", cur_ov(), 32'h2);
    checkOutput("t1_out_data", cur_od(1), 32'h101);
    checkOutput("t1_s_data", cur_sd(), 32'd1);
    checkOutput("t1_s_valid", cur_sv(), 32'd1);
    drain();

    $display("[TB] four flits to port 0, then port 1 header blocked on S");
    sendFlit(9'h000, 3'b000, 1'b0);
    sendFlit(9'h055, 3'b000, 1'b0);
    sendFlit(9'h0AA, 3'b000, 1'b0);
    sendFlit(9'h133, 3'b000, 1'b0);
    applyStimulus(9'h101, 1'b1, 3'b000, 1'b0);
    cycle();
    cycle();
    applyStimulus(9'h101, 1'b1, 3'b000, 1'b1);
    cycle();
    checkOutput("t2_s_data", cur_sd(), 32'd1);
    drain();

    $display("[TB] full FIFO back-pressure in BODY");
    sendFlit(9'h000, 3'b000, 1'b1);
    sendFlit(9'h055, 3'b000, 1'b1);
    sendFlit(9'h0AA, 3'b000, 1'b1);
    sendFlit(9'h0CC, 3'b000, 1'b1);
    applyStimulus(9'h011, 1'b1, 3'b000, 1'b1);
    cycle();
    applyStimulus(9'h011, 1'b1, 3'b001, 1'b1);
    cycle();
    applyStimulus(9'h011, 1'b1, 3'b000, 1'b1);
    cycle();
    sendFlit(9'h1EE, 3'b001, 1'b1);
    drain();

    $display("[TB] reset in the middle of a packet");
    sendFlit(9'h001, 3'b000, 1'b1);
    sendFlit(9'h044, 3'b000, 1'b1);
    doReset();
    sendFlit(9'h000, 3'b000, 1'b1);
    sendFlit(9'h100, 3'b000, 1'b1);
    checkOutput("t6_out_valid", cur_ov(), 32'h1);
    drain();

    $display("[TB] random traffic, two ports");
    randomTraffic(300);
    drain();

    sel  = 1'b1;
    nout = 3;
    doReset();

    $display("[TB] invalid destination dropped");
    sendFlit(9'h003, 3'b000, 1'b1);
    sendFlit(9'h055, 3'b000, 1'b1);
    sendFlit(9'h0AA, 3'b000, 1'b1);
    sendFlit(9'h1FF, 3'b000, 1'b1);
    applyStimulus(9'h000, 1'b0, 3'b000, 1'b1);
    cycle();
    checkOutput("t4_drop", cur_drop(), 32'd1);
    checkOutput("t4_no_out", cur_ov(), 32'd0);
    sendFlit(9'h102, 3'b000, 1'b1);
    checkOutput("t4_route", cur_ov(), 32'h4);
    drain();

    $display("[TB] route record stall");
    sendFlit(9'h100, 3'b000, 1'b0);
    applyStimulus(9'h102, 1'b1, 3'b000, 1'b0);
    cycle();
    cycle();
    applyStimulus(9'h102, 1'b1, 3'b000, 1'b1);
    cycle();
    applyStimulus(9'h000, 1'b0, 3'b000, 1'b0);
    cycle();
    checkOutput("t5_s_data", cur_sd(), 32'd2);
    drain();

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 260; i++) sendFlit(9'h103, 3'b000, 1'b1);
    applyStimulus(9'h000, 1'b0, 3'b000, 1'b1);
    cycle();
    checkOutput("drop_sat", cur_drop(), 32'd255);

    $display("[TB] random traffic, three ports");
    randomTraffic(300);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish (checks=%0d)", checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/noc_route_demux.md
# noc_route_demux

Parametrised, clocked packet demultiplexer for the NoC router datapath. Accepts wormhole packets of W-bit flits on one input channel and steers each whole packet to one of NOUT output channels, selected by the header flit's destination field. Each output has its own DEPTH-entry FIFO. A route-record channel S reports the chosen port per packet. Generalises the fixed two-output, 9-bit decoder to any port count, any flit width and any buffer depth, and adds invalid-destination dropping with a drop counter.

## Interface
- W, 9: flit width; bit W-1 is the tail flag, and bits [AW-1:0] of a header flit are the destination.
- NOUT, 2: number of output ports, ≥2; AW = $clog2(NOUT).
- DEPTH, 4: entries per output FIFO, ≥2.
- CLK  in  1  single clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- In_data  in  W  input flit.
- In_valid  in  1  input flit present.
- In_ready  out  1  input flit accepted when In_valid && In_ready.
- Out_data  out  NOUT*W  per-port flit; port p occupies [p*W +: W].
- Out_valid  out  NOUT  per-port flit present.
- Out_ready  in  NOUT  per-port consumer accepts.
- S_data  out  AW  destination of the most recently routed packet.
- S_valid  out  1  route record present.
- S_ready  in  1  route record consumed.
- drop_cnt  out  8  count of dropped packets; saturates at 255.

## Operation
- FSM states: HEAD, which expects a header flit; BODY, which is locked to port `lock`; DROP, which discards flits up to and including the tail.
- Header flit in HEAD, with dest = In_data[AW-1:0]:
  - dest < NOUT: the flit is pushed to FIFO[dest] and S is loaded with dest. If tail=0, go to BODY with lock = dest; if tail=1, stay in HEAD.
  - dest ≥ NOUT (only possible when NOUT is not a power of two): the flit is discarded and drop_cnt increments. If tail=0, go to DROP; if tail=1, stay in HEAD. S is not loaded.
- BODY: every accepted flit is pushed to FIFO[lock]. The tail flit returns the FSM to HEAD.
- DROP: In_ready=1. Flits are discarded, and the tail flit returns the FSM to HEAD.
- In_ready:
  - HEAD with a valid dest: FIFO[dest] count < DEPTH, and the S slot is free (S_valid=0, or S_ready=1 in the same cycle).
  - HEAD with an invalid dest: 1.
  - BODY: FIFO[lock] count < DEPTH.
  - In_ready may depend combinationally on In_data (dest), S_ready and the FIFO counts.
- A full FIFO is not writable even if it is popped in the same cycle (no pass-through).
- Each FIFO is a circular buffer with rd/wr pointers and a count. A push and a pop in the same cycle leave count unchanged. Pointers wrap from DEPTH-1 to 0.
- Out_valid[p] = (count[p] ≠ 0). Out_data[p] is the head entry, held stable while Out_valid[p] && !Out_ready[p].
- S is a one-entry register. It is set on a valid header accept and cleared on S_valid && S_ready. A simultaneous clear and set loads the new value.
- drop_cnt holds at 255.

## Timing
- Reset (asynchronous assert, synchronous-to-CLK deassert externally) sets:
  - state=HEAD and all FIFO counts and pointers to 0;
  - Out_valid=0, S_valid=0, S_data=0, drop_cnt=0, Out_data=0.
- RESET mid-packet flushes all FIFOs and abandons the packet. The next flit after reset is treated as a header.
- Latency: a flit accepted at edge k is visible on Out_data/Out_valid after edge k. S_valid rises after the same edge as the header's push.
- Throughput: 1 flit/cycle when the target FIFO is not full.
- Output ports drain independently. Back-pressure on one port stalls the input only while that port is the target.

## Test plan
- Single-flit packet to port 1 (NOUT=2, W=9, DEPTH=4): In_data=9'h101 -> Out_valid=2'b10 one cycle later, Out_data[17:9]=9'h101, S_data=1, S_valid=1, state stays HEAD.
- Four-flit packet to port 0, then a packet to port 1, with Out_ready=2'b00 -> four flits fill FIFO[0] and In_ready stays 1 throughout. The port-1 header is accepted only after S is drained. Port-0 order is preserved.
- Fill FIFO[0] to 4 with a packet in BODY -> In_ready=0. Pulse Out_ready[0] for one cycle -> count becomes 3 and In_ready=1 on the next cycle, never in the pop cycle.
- NOUT=3 with header dest=3, tail=0, followed by two body flits and a tail -> all four flits consumed with In_ready=1, no Out_valid, drop_cnt=1. The next header (dest=2) routes normally.
- Hold S_ready=0 and send two single-flit packets -> the first is accepted and the second stalls with In_ready=0. Raise S_ready -> the second is accepted in that same cycle and S_data updates.
- Assert RESET while in BODY with 2 flits buffered -> Out_valid=0 and counts=0 immediately. After release, a flit with tail=0 is routed as a header.
